aes_round_ctrl: RTL and testbench

//  Round sequencer for the AES-128 core. On Start it steps the datapath through the initial AddRoundKey, rounds 1..NR-1 and the final round.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_round_ctrl.sv | 104 ++++++++++
 tb/tb_aes_round_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES round-sequencer constants and FSM state type
//   AES_NR       number of AES-128 rounds
//   AES_KIDX_W   round-key index width
//   ctrl_state_t round sequencer states
//   MODE_ENC/DEC values of the Mode input
package aes_pkg;
   localparam int AES_NR     = 10;
   localparam int AES_KIDX_W = 4;
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;
   typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} ctrl_state_t;
endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer driving round-key selection and datapath strobes
//   clk, rst_n            clock, asynchronous active-low reset
//   Start, Mode           operation request (sampled in IDLE only) and 0=enc/1=dec
//   KeyReady, Abort       key expansion complete; synchronous abort to IDLE
//   SelKeyEnc/SelKeyDec   ascending / descending round-key index
//   EncEn, DecEn          active path select
//   LoadState, RoundEn    round-0 load, per-round enable
//   FinalRound, Busy      last round (no MixColumns), LOAD..FINAL
//   Done                  one-cycle result-valid pulse
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NR     = AES_NR,
   parameter int KIDX_W = AES_KIDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic              Mode,
   input  logic              KeyReady,
   input  logic              Abort,
   output logic [KIDX_W-1:0] SelKeyEnc,
   output logic [KIDX_W-1:0] SelKeyDec,
   output logic              EncEn,
   output logic              DecEn,
   output logic              LoadState,
   output logic              RoundEn,
   output logic              FinalRound,
   output logic              Busy,
   output logic              Done
);
   localparam logic [KIDX_W-1:0] NR_K   = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] LAST_R = KIDX_W'(NR - 1);
   ctrl_state_t       state_q, state_d;
   logic [KIDX_W-1:0] cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              busy_d;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      if (Abort) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE:  if (Start && KeyReady) begin
                      state_d = LOAD;
                      cnt_d   = '0;
                      mode_d  = Mode;
                   end
            LOAD:  begin
                      state_d = (NR == 1) ? FINAL : ROUND;
                      cnt_d   = KIDX_W'(1);
                   end
            ROUND: begin
                      state_d = (cnt_q == LAST_R) ? FINAL : ROUND;
                      cnt_d   = cnt_q + 1'b1;
                   end
            FINAL: state_d = DONE;
            DONE:  begin
                      state_d = IDLE;
                      cnt_d   = '0;
                   end
            default: begin
                      state_d = IDLE;
                      cnt_d   = '0;
                   end
         endcase
      end
      busy_d = (state_d == LOAD) || (state_d == ROUND) || (state_d == FINAL);
   end
   // Outputs are decoded from the next state and registered alongside it, so
   // they are glitch-free yet line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mode_q     <= MODE_ENC;
         SelKeyEnc  <= '0;
         SelKeyDec  <= '0;
         EncEn      <= 1'b0;
         DecEn      <= 1'b0;
         LoadState  <= 1'b0;
         RoundEn    <= 1'b0;
         FinalRound <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         SelKeyEnc  <= busy_d ? cnt_d : '0;
         SelKeyDec  <= busy_d ? NR_K - cnt_d : '0;
         EncEn      <= busy_d && (mode_d == MODE_ENC);
         DecEn      <= busy_d && (mode_d == MODE_DEC);
         LoadState  <= state_d == LOAD;
         RoundEn    <= (state_d == ROUND) || (state_d == FINAL);
         FinalRound <= state_d == FINAL;
         Busy       <= busy_d;
         Done       <= state_d == DONE;
      end
   end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: randomized self-checking bench against a cycle-phase reference model
module tb_aes_round_ctrl;
   import aes_pkg::*;
   localparam int NR = AES_NR;
   localparam int KW = AES_KIDX_W;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic          key_ready = 1'b0;
   logic          abort = 1'b0;
   logic [KW-1:0] sel_enc, sel_dec;
   logic          enc_en, dec_en, load_state, round_en, final_round, busy, done;
   logic [14:0]   outs;
   int            checks = 0;
   int            failures = 0;
   int            phase = 0;
   logic          op_mode = 1'b0;
   aes_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .Start(start), .Mode(mode), .KeyReady(key_ready), .Abort(abort),
      .SelKeyEnc(sel_enc), .SelKeyDec(sel_dec), .EncEn(enc_en), .DecEn(dec_en),
      .LoadState(load_state), .RoundEn(round_en), .FinalRound(final_round), .Busy(busy), .Done(done)
   );
   assign outs = {sel_enc, sel_dec, enc_en, dec_en, load_state, round_en, final_round, busy, done};
   always #5 clk = ~clk;
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   // Phase k counts cycles since Start was accepted: 1 = load, 2..NR = rounds,
   // NR+1 = final round, NR+2 = done pulse, 0 = idle.
   function automatic logic [14:0] expect_out(input int k, input logic m);
      logic      b;
      int        idx;
      b   = (k >= 1) && (k <= NR + 1);
      idx = b ? k - 1 : 0;
      return {KW'(idx), KW'(b ? NR - idx : 0), b && !m, b && m, k == 1,
              (k >= 2) && (k <= NR + 1), k == NR + 1, b, k == NR + 2};
   endfunction
   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      key_ready = 1'b1;
      #12;
      check_eq("reset", 32'(outs), 32'd0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      #1;
      check_eq("reset_release", 32'(outs), 32'd0);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         if (!rst_n || abort) phase = 0;
         else if (phase == 0) begin
            if (start && key_ready) begin
               phase = 1;
               op_mode = mode;
            end
         end else phase = (phase == NR + 2) ? 0 : phase + 1;
         @(negedge clk);
         check_eq("outs", 32'(outs), 32'(expect_out(phase, op_mode)));
         check_eq("excl", 32'(enc_en & dec_en), 32'd0);
         if (!rst_n) rst_n = 1'b1;
         if (cyc < 60) begin
            start     = (cyc == 1) || (cyc >= 16 && cyc <= 30) || cyc == 36 || cyc == 44 || cyc == 50;
            mode      = (cyc >= 16) && (cyc < 40) && (cyc != 21);
            key_ready = !(cyc >= 34 && cyc <= 38);
            abort     = (cyc == 50) || (cyc == 54);
         end else begin
            start     = $urandom_range(0, 3) == 0;
            mode      = 1'($urandom);
            key_ready = $urandom_range(0, 7) != 0;
            abort     = $urandom_range(0, 47) == 0;
            if (phase > 0 && $urandom_range(0, 79) == 0) begin
               rst_n = 1'b0;
               #1;
               check_eq("arst", 32'(outs), 32'd0);
            end
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
